// File: rtl/matrix_pkg.sv
// Shared encodings for the element-wise matrix streamer.
// Holds the operation modes, FSM state encodings and the default maximum dimension.
// Imported by the top module and by the arithmetic sub-module.
package matrix_pkg;

  localparam int MAX_DIM_DEFAULT = 5;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_MUL  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    COMPUTE = 3'd2,
    EMIT    = 3'd3,
    FINISH  = 3'd4
  } state_e;

endpackage

// File: rtl/elem_alu.sv
// Element ALU: A+B, A-B or A*scalar at full precision, then reduced to RES_WIDTH.
// Latency: combinational. Backpressure: none, the caller registers the result.
// MATRIX_ELEMWISE_SAT_EN selects clamping; otherwise the low RES_WIDTH bits are kept.
module elem_alu
  import matrix_pkg::*;
#(
  parameter int ELEM_WIDTH = 8,
  parameter int RES_WIDTH  = 16
) (
  input  logic [ELEM_WIDTH-1:0] a,
  input  logic [ELEM_WIDTH-1:0] b,
  input  logic [ELEM_WIDTH-1:0] scalar,
  input  mode_e                 mode,
  output logic [RES_WIDTH-1:0]  res
);

  localparam int FW = 2*ELEM_WIDTH + 1;

  logic signed [FW-1:0] a_x;
  logic signed [FW-1:0] b_x;
  logic signed [FW-1:0] s_x;
  logic signed [FW-1:0] full;

  // Operands are unsigned, so zero-extend into the signed full-precision domain.
  assign a_x = {{(ELEM_WIDTH+1){1'b0}}, a};
  assign b_x = {{(ELEM_WIDTH+1){1'b0}}, b};
  assign s_x = {{(ELEM_WIDTH+1){1'b0}}, scalar};

  // Full-precision result; the product of two unsigned elements always fits in FW bits.
  always_comb begin
    full = '0;
    case (mode)
      MODE_ADD: full = a_x + b_x;
      MODE_SUB: full = a_x - b_x;
      MODE_MUL: full = a_x * s_x;
      default:  full = '0;
    endcase
  end

`ifdef MATRIX_ELEMWISE_SAT_EN
  localparam logic signed [FW-1:0] RMAX = {{(FW-RES_WIDTH+1){1'b0}}, {(RES_WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] RMIN = {{(FW-RES_WIDTH+1){1'b1}}, {(RES_WIDTH-1){1'b0}}};

  // Clamp to the representable signed RES_WIDTH range.
  always_comb begin
    if (full > RMAX) begin
      res = RMAX[RES_WIDTH-1:0];
    end else if (full < RMIN) begin
      res = RMIN[RES_WIDTH-1:0];
    end else begin
      res = full[RES_WIDTH-1:0];
    end
  end
`else
  logic unused_full;
  assign unused_full = ^full;

  // Wrap: keep the low RES_WIDTH bits.
  always_comb begin
    res = full[RES_WIDTH-1:0];
  end
`endif

endmodule

// File: rtl/matrix_elemwise_stream.sv
// Streams an element-wise matrix op (A+B, A-B, A*scalar) one element at a time, row-major.
// Latency: start to first out_valid 3 cycles; at most one element per 2 cycles.
// Backpressure: out_valid/out_data held stable until out_ready; abort cancels at any point.
// Saturation is compiled in with MATRIX_ELEMWISE_SAT_EN (wrap otherwise).
module matrix_elemwise_stream
  import matrix_pkg::*;
#(
  parameter int ELEM_WIDTH = 8,
  parameter int MAX_DIM    = MAX_DIM_DEFAULT,
  parameter int RES_WIDTH  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [1:0]                            mode,
  input  logic [3:0]                            m,
  input  logic [3:0]                            n,
  input  logic [ELEM_WIDTH-1:0]                 scalar,
  input  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] in_a,
  input  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] in_b,
  input  logic                                  out_ready,
  output logic                                  out_valid,
  output logic [RES_WIDTH-1:0]                  out_data,
  output logic                                  out_eol,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int MW = MAX_DIM*MAX_DIM*ELEM_WIDTH;
  localparam int IW = $clog2(MAX_DIM*MAX_DIM + 1);

  state_e                state;
  mode_e                 mode_q;
  logic [3:0]            m_q;
  logic [3:0]            n_q;
  logic [ELEM_WIDTH-1:0] scalar_q;
  logic [MW-1:0]         in_a_q;
  logic [MW-1:0]         in_b_q;
  logic [3:0]            i;
  logic [3:0]            j;
  logic [IW-1:0]         idx;
  logic [ELEM_WIDTH-1:0] a_sel;
  logic [ELEM_WIDTH-1:0] b_sel;
  logic [RES_WIDTH-1:0]  res;
  logic                  dim_err;

  // Linear row-major index kept alongside (i,j) so element selection needs no multiply by n.
  always_comb begin
    a_sel = in_a_q[int'(idx)*ELEM_WIDTH +: ELEM_WIDTH];
    b_sel = in_b_q[int'(idx)*ELEM_WIDTH +: ELEM_WIDTH];
  end

  // Operation is rejected for empty or oversize dimensions and for the reserved mode.
  always_comb begin
    dim_err = (m_q == 4'd0) || (n_q == 4'd0) ||
              (int'(m_q) > MAX_DIM) || (int'(n_q) > MAX_DIM) ||
              (mode_q == MODE_RSVD);
  end

  elem_alu #(
    .ELEM_WIDTH (ELEM_WIDTH),
    .RES_WIDTH  (RES_WIDTH)
  ) u_alu (
    .a      (a_sel),
    .b      (b_sel),
    .scalar (scalar_q),
    .mode   (mode_q),
    .res    (res)
  );

  // Control FSM with registered outputs; abort outranks every other transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= MODE_ADD;
      m_q       <= '0;
      n_q       <= '0;
      scalar_q  <= '0;
      in_a_q    <= '0;
      in_b_q    <= '0;
      i         <= '0;
      j         <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mode_q   <= mode_e'(mode);
              m_q      <= m;
              n_q      <= n;
              scalar_q <= scalar;
              in_a_q   <= in_a;
              in_b_q   <= in_b;
              i        <= '0;
              j        <= '0;
              idx      <= '0;
              busy     <= 1'b1;
              err      <= 1'b0;
              state    <= CHECK;
            end
          end
          CHECK: begin
            if (dim_err) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              state <= COMPUTE;
            end
          end
          COMPUTE: begin
            out_data  <= res;
            out_eol   <= (j == n_q - 4'd1);
            out_last  <= (j == n_q - 4'd1) && (i == m_q - 4'd1);
            out_valid <= 1'b1;
            state     <= EMIT;
          end
          EMIT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (out_last) begin
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                if (out_eol) begin
                  j <= '0;
                  i <= i + 4'd1;
                end else begin
                  j <= j + 4'd1;
                end
                idx   <= idx + 1'b1;
                state <= COMPUTE;
              end
            end
          end
          FINISH: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_elemwise_stream.sv
// Directed self-checking bench for matrix_elemwise_stream.
// Runs a 16-bit result instance plus a 10-bit result instance on shared stimulus.
// Expected values follow MATRIX_ELEMWISE_SAT_EN when it is defined.
module tb_matrix_elemwise_stream;

  localparam int EW = 8;
  localparam int MD = 5;
  localparam int BW = MD*MD*EW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [3:0]    m = 4'd0;
  logic [3:0]    n = 4'd0;
  logic [EW-1:0] scalar = '0;
  logic [BW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_eol;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;
  logic          v10;
  logic [9:0]    d10;
  logic          eol10;
  logic          last10;
  logic          busy10;
  logic          done10;
  logic          err10;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q_d[$];
  logic [15:0] q_d10[$];
  logic        q_eol[$];
  logic        q_last[$];
  int          first_valid;
  int          done_cyc;
  logic        err_at_done;
  int          stab_err;

  matrix_elemwise_stream #(.ELEM_WIDTH(EW), .MAX_DIM(MD), .RES_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .m(m), .n(n),
    .scalar(scalar), .in_a(in_a), .in_b(in_b), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_eol(out_eol), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  matrix_elemwise_stream #(.ELEM_WIDTH(EW), .MAX_DIM(MD), .RES_WIDTH(10)) dut10 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .m(m), .n(n),
    .scalar(scalar), .in_a(in_a), .in_b(in_b), .out_ready(out_ready),
    .out_valid(v10), .out_data(d10), .out_eol(eol10), .out_last(last10),
    .busy(busy10), .done(done10), .err(err10)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] md, input logic [3:0] mm, input logic [3:0] nn,
                          input logic [EW-1:0] sc);
    mode = md; m = mm; n = nn; scalar = sc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Collect handshaked elements until done or budget; cycle 0 is the cycle after start is taken.
  task automatic collect(input int budget, input bit rnd);
    bit                 stalled = 1'b0;
    logic [18:0]        held = '0;
    q_d.delete(); q_d10.delete(); q_eol.delete(); q_last.delete();
    first_valid = -1; done_cyc = -1; err_at_done = 1'b0; stab_err = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (stalled && ({out_valid, out_data, out_eol, out_last} !== held)) stab_err++;
      if (done) begin
        done_cyc = cyc;
        err_at_done = err;
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        q_d.push_back(out_data);
        q_d10.push_back({6'd0, d10});
        q_eol.push_back(out_eol);
        q_last.push_back(out_last);
      end
      stalled = out_valid && !out_ready;
      held = {out_valid, out_data, out_eol, out_last};
      tick();
    end
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] pack_bits(input int which);
    logic [31:0] r = '0;
    for (int k = 0; k < q_eol.size() && k < 32; k++) r[k] = (which == 0) ? q_eol[k] : q_last[k];
    return r;
  endfunction

  logic [31:0] exp_w;
  logic [31:0] eol_exp;
  int          seen;
  bit          hit;
  bit          done_seen;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_eol_last", {30'd0, out_eol, out_last}, 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b0;
    tick();

    // Mode 0, 2x3, A=1..6, B=10 -> 11..16
    in_a = '0; in_b = '0;
    for (int k = 0; k < 6; k++) begin in_a[k*EW +: EW] = 8'(k + 1); in_b[k*EW +: EW] = 8'd10; end
    out_ready = 1'b1;
    do_start(2'd0, 4'd2, 4'd3, 8'd0);
    check("add_busy", {31'd0, busy}, 32'd1);
    collect(60, 1'b0);
    check("add_latency", first_valid, 32'd2);
    check("add_count", q_d.size(), 32'd6);
    for (int k = 0; k < q_d.size(); k++) check($sformatf("add_data%0d", k), {16'd0, q_d[k]}, 32'(11 + k));
    check("add_eol", pack_bits(0), 32'b100100);
    check("add_last", pack_bits(1), 32'b100000);
    check("add_done_cyc", done_cyc, 32'd13);
    check("add_err", {31'd0, err_at_done}, 32'd0);
    tick();
    check("add_done_pulse", {30'd0, done, busy}, 32'd0);

    // Mode 1, 1x1, 3-200 = -197
    in_a[7:0] = 8'd3; in_b[7:0] = 8'd200;
    do_start(2'd1, 4'd1, 4'd1, 8'd0);
    collect(30, 1'b0);
    check("sub_count", q_d.size(), 32'd1);
    if (q_d.size() > 0) check("sub_data", {16'd0, q_d[0]}, 32'h0000_FF3B);
    tick();

    // Mode 2, 1x1, 255*255 = 65025
    in_a[7:0] = 8'd255;
    do_start(2'd2, 4'd1, 4'd1, 8'd255);
    collect(30, 1'b0);
    check("mul_count", q_d.size(), 32'd1);
`ifdef MATRIX_ELEMWISE_SAT_EN
    if (q_d.size() > 0) check("mul_data16", {16'd0, q_d[0]}, 32'h7FFF);
    if (q_d10.size() > 0) check("mul_data10", {16'd0, q_d10[0]}, 32'h01FF);
`else
    if (q_d.size() > 0) check("mul_data16", {16'd0, q_d[0]}, 32'hFE01);
    if (q_d10.size() > 0) check("mul_data10", {16'd0, q_d10[0]}, 32'h0201);
`endif
    tick();

    // Rejected operations: m=0, n=6, mode=3
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       do_start(2'd0, 4'd0, 4'd2, 8'd0);
        1:       do_start(2'd0, 4'd2, 4'd6, 8'd0);
        default: do_start(2'd3, 4'd2, 4'd2, 8'd0);
      endcase
      collect(20, 1'b0);
      check($sformatf("err%0d_nvalid", t), {31'd0, first_valid >= 0}, 32'd0);
      check($sformatf("err%0d_done_cyc", t), done_cyc, 32'd1);
      check($sformatf("err%0d_err", t), {31'd0, err_at_done}, 32'd1);
      tick();
    end
    tick();
    check("err_holds", {30'd0, err, busy}, 32'd2);

    // 5x5 add under random backpressure: A=k, B=10k -> 11k
    for (int k = 0; k < 25; k++) begin in_a[k*EW +: EW] = 8'(k); in_b[k*EW +: EW] = 8'(10*k); end
    do_start(2'd0, 4'd5, 4'd5, 8'd0);
    collect(800, 1'b1);
    check("bp_count", q_d.size(), 32'd25);
    exp_w = 32'd0;
    for (int k = 0; k < q_d.size(); k++) if (q_d[k] !== 16'(11*k)) exp_w++;
    check("bp_order", exp_w, 32'd0);
    check("bp_stable", stab_err, 32'd0);
    eol_exp = 32'h0108_4210;
    check("bp_eol", pack_bits(0), eol_exp);
    check("bp_last", pack_bits(1), 32'h0100_0000);
    check("bp_err", {31'd0, err_at_done}, 32'd0);
    tick();

    // Abort while the 4th element of a 2x3 add is presented
    for (int k = 0; k < 6; k++) begin in_a[k*EW +: EW] = 8'(k + 1); in_b[k*EW +: EW] = 8'd10; end
    out_ready = 1'b1;
    do_start(2'd0, 4'd2, 4'd3, 8'd0);
    seen = 0; hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (out_valid) begin
        if (seen == 3) begin
          hit = 1'b1;
          check("abort_elem4", {16'd0, out_data}, 32'd14);
          abort = 1'b1;
        end else begin
          seen++;
        end
      end
      tick();
    end
    abort = 1'b0;
    check("abort_hit", {31'd0, hit}, 32'd1);
    check("abort_idle", {30'd0, out_valid, busy}, 32'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin done_seen |= done; tick(); end
    check("abort_nodone", {31'd0, done_seen}, 32'd0);

    // Normal run after abort: 7*9 = 63
    in_a[7:0] = 8'd7;
    do_start(2'd2, 4'd1, 4'd1, 8'd9);
    collect(30, 1'b0);
    check("post_abort_data", (q_d.size() == 1) ? {16'd0, q_d[0]} : 32'hDEAD, 32'd63);
    tick();

    // Reset while an element is held in EMIT
    in_a[7:0] = 8'd5; in_b[7:0] = 8'd6;
    out_ready = 1'b0;
    do_start(2'd0, 4'd1, 4'd1, 8'd0);
    tick(); tick();
    check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {29'd0, out_valid, busy, done}, 32'd0);
    tick();
    rst = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin done_seen |= done; tick(); end
    check("rst_nodone", {31'd0, done_seen}, 32'd0);
    out_ready = 1'b1;
    do_start(2'd0, 4'd1, 4'd1, 8'd0);
    collect(30, 1'b0);
    check("post_rst_data", (q_d.size() == 1) ? {16'd0, q_d[0]} : 32'hDEAD, 32'd11);
    check("post_rst_done_cyc", done_cyc, 32'd3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
